// File: rtl/mem_port_arbiter_if.sv
// Request/grant and memory-side signals shared by the fetch/LS arbiter.
// master: requesters plus memory environment; slave: the arbiter itself.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned BeW = DATA_W / 8;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              ls_req;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic [BeW-1:0]    ls_be;
  logic              ls_gnt;
  logic              ls_rvalid;
  logic [DATA_W-1:0] ls_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BeW-1:0]    mem_be;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_be, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_be, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single-port synchronous memory: LS has priority,
// a starvation counter forces a fetch grant, and read returns are routed by owner.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);
  localparam int unsigned BeW       = DATA_W / 8;
  localparam logic [3:0]  StarveMax = 4'(STARVE_MAX);

  logic              if_gnt;
  logic              ls_gnt;
  logic              starve_hit;
  logic              rd_push;
  logic              if_rvalid;
  logic              ls_rvalid;
  logic [3:0]        starve_cnt_q;
  logic [3:0]        starve_cnt_d;
  // Return pipeline; owner bit 1 = LS, 0 = IF.
  logic [RD_LAT-1:0] ret_valid_q;
  logic [RD_LAT-1:0] ret_owner_q;

  assign starve_hit = bus.if_req && (starve_cnt_q == StarveMax);

  // Grants are held off entirely while reset is asserted.
  always_comb begin
    if_gnt = 1'b0;
    ls_gnt = 1'b0;
    if (rst) begin
      if (bus.ls_req && !starve_hit) begin
        ls_gnt = 1'b1;
      end else if (bus.if_req) begin
        if_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_be    = '0;
    if (ls_gnt) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = bus.ls_we;
      bus.mem_addr  = bus.ls_addr;
      bus.mem_wdata = bus.ls_wdata;
      bus.mem_be    = bus.ls_be;
    end else if (if_gnt) begin
      bus.mem_en   = 1'b1;
      bus.mem_addr = bus.if_addr;
      bus.mem_be   = {BeW{1'b1}};
    end
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (if_gnt || !bus.if_req) begin
      starve_cnt_d = '0;
    end else if (ls_gnt && (starve_cnt_q != StarveMax)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  assign rd_push = if_gnt || (ls_gnt && !bus.ls_we);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt_q <= '0;
      ret_valid_q  <= '0;
      ret_owner_q  <= '0;
    end else begin
      starve_cnt_q   <= starve_cnt_d;
      ret_valid_q[0] <= rd_push;
      ret_owner_q[0] <= ls_gnt;
      for (int i = 1; i < int'(RD_LAT); i++) begin
        ret_valid_q[i] <= ret_valid_q[i-1];
        ret_owner_q[i] <= ret_owner_q[i-1];
      end
    end
  end

  assign if_rvalid = ret_valid_q[RD_LAT-1] && !ret_owner_q[RD_LAT-1];
  assign ls_rvalid = ret_valid_q[RD_LAT-1] &&  ret_owner_q[RD_LAT-1];

  assign bus.if_gnt    = if_gnt;
  assign bus.ls_gnt    = ls_gnt;
  assign bus.if_rvalid = if_rvalid;
  assign bus.ls_rvalid = ls_rvalid;
  assign bus.if_rdata  = if_rvalid ? bus.mem_rdata : '0;
  assign bus.ls_rdata  = ls_rvalid ? bus.mem_rdata : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Drives identical stimulus into RD_LAT=1 and RD_LAT=3 arbiters, each with a
// behavioural memory; a scoreboard checks owner, data and return cycle.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        ls_req = 1'b0;
  logic        ls_we = 1'b0;
  logic [31:0] ls_addr = '0;
  logic [31:0] ls_wdata = '0;
  logic [3:0]  ls_be = '0;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b3 ();

  assign b1.if_req = if_req;  assign b3.if_req = if_req;
  assign b1.if_addr = if_addr; assign b3.if_addr = if_addr;
  assign b1.ls_req = ls_req;  assign b3.ls_req = ls_req;
  assign b1.ls_we = ls_we;    assign b3.ls_we = ls_we;
  assign b1.ls_addr = ls_addr; assign b3.ls_addr = ls_addr;
  assign b1.ls_wdata = ls_wdata; assign b3.ls_wdata = ls_wdata;
  assign b1.ls_be = ls_be;    assign b3.ls_be = ls_be;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1), .STARVE_MAX(4)) dut1 (
    .clk(clk), .rst(rst), .bus(b1)
  );
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(3), .STARVE_MAX(4)) dut3 (
    .clk(clk), .rst(rst), .bus(b3)
  );

  // Behavioural memories: RD_LAT=1 and RD_LAT=3.
  logic [31:0] mem1 [256];
  logic [31:0] mem3 [256];
  logic [31:0] rd1;
  logic [31:0] rd3 [3];
  assign b1.mem_rdata = rd1;
  assign b3.mem_rdata = rd3[2];

  always @(posedge clk) begin
    rd1 <= '0;
    if (b1.mem_en) begin
      if (b1.mem_we) begin
        for (int k = 0; k < 4; k++)
          if (b1.mem_be[k]) mem1[b1.mem_addr[9:2]][8*k +: 8] <= b1.mem_wdata[8*k +: 8];
      end else begin
        rd1 <= mem1[b1.mem_addr[9:2]];
      end
    end
  end

  always @(posedge clk) begin
    rd3[1] <= rd3[0];
    rd3[2] <= rd3[1];
    rd3[0] <= '0;
    if (b3.mem_en) begin
      if (b3.mem_we) begin
        for (int k = 0; k < 4; k++)
          if (b3.mem_be[k]) mem3[b3.mem_addr[9:2]][8*k +: 8] <= b3.mem_wdata[8*k +: 8];
      end else begin
        rd3[0] <= mem3[b3.mem_addr[9:2]];
      end
    end
  end

  typedef struct {
    bit          ls;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t q1[$];
  exp_t q3[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push_rd(input bit ls, input logic [31:0] data);
    q1.push_back('{ls: ls, data: data, due: cyc + 1});
    q3.push_back('{ls: ls, data: data, due: cyc + 3});
  endtask

  task automatic chk_gnt(input string nm, input bit eif, input bit els);
    chk(nm, {b1.if_gnt, b1.ls_gnt, b3.if_gnt, b3.ls_gnt}, {eif, els, eif, els});
  endtask

  // Scoreboard monitors.
  always @(negedge clk) begin
    exp_t e;
    chk("lat1 rdata qualified", {b1.if_rvalid ? 32'h0 : b1.if_rdata,
                                 b1.ls_rvalid ? 32'h0 : b1.ls_rdata}, 64'h0);
    if (b1.if_rvalid || b1.ls_rvalid) begin
      if (q1.size() == 0) begin
        chk("lat1 unexpected rvalid", {b1.if_rvalid, b1.ls_rvalid}, 64'h0);
      end else begin
        e = q1.pop_front();
        chk("lat1 owner", {b1.if_rvalid, b1.ls_rvalid}, e.ls ? 2'b01 : 2'b10);
        chk("lat1 rdata", e.ls ? b1.ls_rdata : b1.if_rdata, e.data);
        chk("lat1 cycle", cyc, e.due);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    chk("lat3 rdata qualified", {b3.if_rvalid ? 32'h0 : b3.if_rdata,
                                 b3.ls_rvalid ? 32'h0 : b3.ls_rdata}, 64'h0);
    if (b3.if_rvalid || b3.ls_rvalid) begin
      if (q3.size() == 0) begin
        chk("lat3 unexpected rvalid", {b3.if_rvalid, b3.ls_rvalid}, 64'h0);
      end else begin
        e = q3.pop_front();
        chk("lat3 owner", {b3.if_rvalid, b3.ls_rvalid}, e.ls ? 2'b01 : 2'b10);
        chk("lat3 rdata", e.ls ? b3.ls_rdata : b3.if_rdata, e.data);
        chk("lat3 cycle", cyc, e.due);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_req = 1'b0;
    ls_req = 1'b0;
    ls_we  = 1'b0;
  endtask

  task automatic set_if(input logic [31:0] a);
    if_req  = 1'b1;
    if_addr = a;
  endtask

  task automatic set_ls(input bit we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be);
    ls_req = 1'b1; ls_we = we; ls_addr = a; ls_wdata = wd; ls_be = be;
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 20 && (q1.size() != 0 || q3.size() != 0); i++) step();
    chk(nm, {32'(q1.size()), 32'(q3.size())}, 64'h0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem1[i] = '0;
      mem3[i] = '0;
    end
    mem1[8'h40] = 32'hDEADBEEF; mem3[8'h40] = 32'hDEADBEEF;  // 0x100
    mem1[8'h41] = 32'h11111111; mem3[8'h41] = 32'h11111111;  // 0x104
    mem1[8'h42] = 32'h33333333; mem3[8'h42] = 32'h33333333;  // 0x108
    mem1[8'h80] = 32'hCAFEF00D; mem3[8'h80] = 32'hCAFEF00D;  // 0x200
    mem1[8'h81] = 32'h22222222; mem3[8'h81] = 32'h22222222;  // 0x204
    rd1 = '0;
    for (int i = 0; i < 3; i++) rd3[i] = '0;

    // Reset state, grants suppressed with req high during reset.
    if_req = 1'b1;
    ls_req = 1'b1;
    @(negedge clk);
    chk_gnt("gnt in reset", 1'b0, 1'b0);
    chk("rvalid in reset", {b1.if_rvalid, b1.ls_rvalid, b3.if_rvalid, b3.ls_rvalid}, 0);
    chk("starve reset", {dut1.starve_cnt_q, dut3.starve_cnt_q}, 0);
    idle();
    step();
    rst = 1'b1;

    // IF read only.
    step();
    set_if(32'h100);
    @(negedge clk);
    chk_gnt("if only gnt", 1'b1, 1'b0);
    chk("if only mem", {b3.mem_en, b3.mem_we, b3.mem_be, b3.mem_addr}, {1'b1, 1'b0, 4'hF, 32'h100});
    push_rd(1'b0, 32'hDEADBEEF);
    step();
    idle();
    @(negedge clk);
    chk("idle mem", {b3.mem_en, b3.mem_we, b3.mem_be, b3.mem_addr | b3.mem_wdata}, 0);
    drain("drain if only");

    // Simultaneous requests: LS first, then IF.
    step();
    set_if(32'h104);
    set_ls(1'b0, 32'h200, 32'h0, 4'hF);
    @(negedge clk);
    chk_gnt("both ls wins", 1'b0, 1'b1);
    chk("both mem addr", b3.mem_addr, 32'h200);
    push_rd(1'b1, 32'hCAFEF00D);
    step();
    ls_req = 1'b0;
    @(negedge clk);
    chk_gnt("if after ls", 1'b1, 1'b0);
    push_rd(1'b0, 32'h11111111);
    step();
    idle();
    drain("drain both");

    // Starvation guard: 4 LS grants, then IF, then LS resumes.
    step();
    set_if(32'h108);
    set_ls(1'b0, 32'h204, 32'h0, 4'hF);
    for (int i = 0; i < 10; i++) begin
      bit if_turn;
      if (i > 0) step();
      if_turn = (i == 4) || (i == 9);
      @(negedge clk);
      chk_gnt($sformatf("starve gnt %0d", i), if_turn, !if_turn);
      if (i == 4) chk("starve cnt max", dut3.starve_cnt_q, 4);
      if (i == 5) chk("starve cnt clr", {dut1.starve_cnt_q, dut3.starve_cnt_q}, 0);
      push_rd(!if_turn, if_turn ? 32'h33333333 : 32'h22222222);
    end
    step();
    idle();
    drain("drain starve");

    // Partial-byte store, then IF read of the same word.
    step();
    set_ls(1'b1, 32'h300, 32'h12345678, 4'b0011);
    @(negedge clk);
    chk_gnt("store gnt", 1'b0, 1'b1);
    chk("store mem", {b3.mem_we, b3.mem_be, b3.mem_wdata}, {1'b1, 4'b0011, 32'h12345678});
    step();
    idle();
    set_if(32'h300);
    @(negedge clk);
    chk_gnt("read back gnt", 1'b1, 1'b0);
    push_rd(1'b0, 32'h00005678);
    step();
    idle();
    drain("drain store");

    // Alternating IF/LS reads back to back, then a store with reads in flight.
    step();
    set_if(32'h100);
    @(negedge clk); chk_gnt("alt 0", 1'b1, 1'b0); push_rd(1'b0, 32'hDEADBEEF);
    step(); idle(); set_ls(1'b0, 32'h200, 32'h0, 4'hF);
    @(negedge clk); chk_gnt("alt 1", 1'b0, 1'b1); push_rd(1'b1, 32'hCAFEF00D);
    step(); idle(); set_if(32'h104);
    @(negedge clk); chk_gnt("alt 2", 1'b1, 1'b0); push_rd(1'b0, 32'h11111111);
    step(); idle(); set_ls(1'b0, 32'h204, 32'h0, 4'hF);
    @(negedge clk); chk_gnt("alt 3", 1'b0, 1'b1); push_rd(1'b1, 32'h22222222);
    step(); idle(); set_ls(1'b1, 32'h308, 32'hAABBCCDD, 4'hF);
    @(negedge clk); chk_gnt("alt store", 1'b0, 1'b1);
    step();
    idle();
    drain("drain alt");

    // Reset with reads in flight on the RD_LAT=3 instance.
    step();
    set_if(32'h100);
    @(negedge clk); chk_gnt("rst rd 0", 1'b1, 1'b0); push_rd(1'b0, 32'hDEADBEEF);
    step(); idle(); set_ls(1'b0, 32'h200, 32'h0, 4'hF);
    @(negedge clk); chk_gnt("rst rd 1", 1'b0, 1'b1); push_rd(1'b1, 32'hCAFEF00D);
    step(); idle();
    step();
    chk("pre-reset rvalid", {b3.if_rvalid, b3.ls_rvalid}, 2'b10);
    #1 rst = 1'b0;
    q1.delete();
    q3.delete();
    #1;
    chk("rvalid drop", {b1.if_rvalid, b1.ls_rvalid, b3.if_rvalid, b3.ls_rvalid}, 0);
    if_req = 1'b1;
    ls_req = 1'b1;
    @(negedge clk);
    chk_gnt("gnt held in reset", 1'b0, 1'b0);
    chk("mem_en in reset", {b1.mem_en, b3.mem_en}, 0);
    step();
    step();
    idle();
    rst = 1'b1;
    repeat (6) step();
    set_if(32'h104);
    @(negedge clk); chk_gnt("post-reset gnt", 1'b1, 1'b0); push_rd(1'b0, 32'h11111111);
    step();
    idle();
    drain("drain post-reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous memory between two requesters: the instruction-fetch stage (IF) and the load/store unit (LS).
- Sits between the pipeline and the unified memory inside top.
- Issues at most one grant per cycle and routes each read return to the requester that issued it.
- Gives LS priority, with a starvation guard so fetch always makes progress.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (byte enables are DATA_W/8)
RD_LAT, 1, memory read latency in cycles from mem_en to mem_rdata valid (legal 1..4)
STARVE_MAX, 4, max consecutive LS grants allowed while if_req is pending (legal 1..15)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
if_req  in  1  fetch read request
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  fetch request accepted this cycle
if_rvalid  out  1  fetch read data valid
if_rdata  out  DATA_W  fetch read data
ls_req  in  1  load/store request
ls_we  in  1  1 = store, 0 = load
ls_addr  in  ADDR_W  load/store address
ls_wdata  in  DATA_W  store data
ls_be  in  DATA_W/8  store byte enables
ls_gnt  out  1  load/store request accepted this cycle
ls_rvalid  out  1  load data valid
ls_rdata  out  DATA_W  load data
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_be  out  DATA_W/8  memory byte enables
mem_rdata  in  DATA_W  memory read data, valid RD_LAT cycles after a read strobe

Behaviour:
- Requester protocol:
  - Requesters hold req and payload stable until gnt.
  - Grant is combinational in the same cycle as req; the access completes on the clock edge where gnt=1.
- Arbitration:
  - Only one requester active: it is granted.
  - Both active: LS wins unless starve_cnt == STARVE_MAX, in which case IF wins.
  - if_gnt and ls_gnt are never both 1.
- starve_cnt register (4 bits):
  - Increments on each cycle with ls_gnt=1 while if_req=1.
  - Clears on if_gnt=1 or if_req=0.
  - Saturates at STARVE_MAX.
- Memory outputs:
  - mem_* are combinational from the granted requester.
  - IF grant drives mem_we=0 and mem_be all-ones.
  - No grant drives mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0.
- Return routing:
  - A RD_LAT-deep shift register of {valid, owner} is pushed every cycle.
  - valid = granted read (mem_en & ~mem_we); owner = IF/LS.
  - At the output stage: if_rvalid = valid & owner==IF, ls_rvalid = valid & owner==LS.
  - rdata outputs are driven from mem_rdata, qualified by their rvalid (0 when not valid).
- Latency and throughput:
  - rvalid asserts exactly RD_LAT cycles after the granting edge.
  - Back-to-back reads sustain one per cycle with in-order returns.
  - Interleaved IF/LS returns are never swapped.
- Stores:
  - Accepted in the grant cycle.
  - Produce no rvalid.
  - A store granted with reads in flight does not disturb their returns.
- Reset (rst=0, asynchronous):
  - All registered outputs and state go to 0: shift register cleared, starve_cnt=0, if_rvalid=ls_rvalid=0.
  - In-flight reads are discarded and never returned after reset release.
  - Grants are suppressed while rst=0, even if req is high.
- Invariant: if_rvalid and ls_rvalid are never both 1.

Test Plan:
- IF read only, RD_LAT=1, if_addr=0x100, memory word 0xDEADBEEF -> if_gnt=1 same cycle, mem_en=1, mem_addr=0x100; one cycle later if_rvalid=1, if_rdata=0xDEADBEEF, ls_rvalid=0.
- Simultaneous if_req and ls_req load at 0x200 -> ls_gnt=1, if_gnt=0; next cycle (ls_req low) if_gnt=1; ls_rvalid precedes if_rvalid by 1 cycle.
- ls_req held high continuously with if_req high, STARVE_MAX=4 -> ls_gnt on 4 consecutive cycles, 5th cycle if_gnt=1, then LS resumes; starve_cnt returns to 0.
- LS store ls_we=1, ls_addr=0x300, ls_wdata=0x12345678, ls_be=4'b0011 -> mem_we=1, mem_be=4'b0011 in grant cycle; no rvalid; subsequent IF read of 0x300 returns 0x00005678 (memory preloaded 0).
- RD_LAT=3, alternating IF/LS reads on 4 consecutive cycles -> rvalids on cycles 3..6 in the same IF/LS/IF/LS order, each with the matching data.
- Assert rst=0 while two reads are in flight (RD_LAT=3) -> all rvalid drop immediately; after release no stale rvalid; first new read returns correctly RD_LAT cycles after its grant.
